// File: rtl/raytracing_scheduler_if.sv
// Raster pixel stream from the ray-tracing scheduler to the frame buffer.
// Valid/ready handshake; the scheduler is the master, the frame buffer the slave.
interface raytracing_scheduler_if #(
  parameter int COLOR_B = 12
);
  logic                px_valid;
  logic                px_ready;
  logic signed [11:0]  px_x;
  logic signed [11:0]  px_y;
  logic [COLOR_B-1:0]  px_color;

  modport master (
    output px_valid,
    output px_x,
    output px_y,
    output px_color,
    input  px_ready
  );

  modport slave (
    input  px_valid,
    input  px_x,
    input  px_y,
    input  px_color,
    output px_ready
  );
endinterface

// File: rtl/raytracing_scheduler.sv
// Frame scheduler: walks the screen in raster order, dispatches the worker pool
// chunk by chunk and drains their colour buffers into a raster pixel stream.
module raytracing_scheduler #(
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 4,
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  parameter int FP_B             = 4,
  parameter int COLOR_B          = 12
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          frame_start,
  input  logic signed [15:0]                            sphere_y,
  output logic                                          frame_busy,
  output logic                                          frame_done,
  output logic [N_WORKERS-1:0]                          worker_activate,
  input  logic [N_WORKERS-1:0]                          worker_busy,
  output logic [12*N_WORKERS-1:0]                       worker_pixel_start_x,
  output logic signed [21:0]                            worker_doty,
  output logic [15:0]                                   worker_pixel_y_sqrd,
  output logic [26:0]                                   worker_sphere_y_sqrd,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_B-1:0] worker_buffer,
  raytracing_scheduler_if.master                        px
);

  localparam int C  = N_WORKERS * JOBS_SUBDIVISION;
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  localparam logic signed [11:0] X_FIRST      = 12'(-(WIDTH / 2));
  localparam logic signed [11:0] X_LAST_CHUNK = 12'(WIDTH / 2 - C);
  localparam logic signed [11:0] Y_FIRST      = 12'(-(HEIGHT / 2));
  localparam logic signed [11:0] Y_LAST       = 12'(HEIGHT / 2 - 1);
  localparam logic [IW-1:0]      IDX_LAST     = IW'(C - 1);

  generate
    if (WIDTH % C != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of N_WORKERS*JOBS_SUBDIVISION");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_SETUP,
    S_DISPATCH,
    S_WAIT,
    S_RELEASE,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic signed [11:0]       y_q, y_d;
  logic signed [11:0]       cx_q, cx_d;
  logic signed [15:0]       sphereY_q, sphereY_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [N_WORKERS-1:0]     seen_q, seen_d;
  logic [N_WORKERS-1:0]     done_q, done_d;
  logic [N_WORKERS-1:0]     activate_q, activate_d;
  logic [12*N_WORKERS-1:0]  startX_q, startX_d;
  logic signed [21:0]       doty_q, doty_d;
  logic [15:0]              pixYSq_q, pixYSq_d;
  logic [26:0]              sphSq_q, sphSq_d;
  logic                     busy_q, busy_d;
  logic                     frameDone_q, frameDone_d;
  logic                     pxValid_q, pxValid_d;
  logic signed [11:0]       pxX_q, pxX_d;
  logic signed [11:0]       pxY_q, pxY_d;
  logic [COLOR_B-1:0]       pxColor_q, pxColor_d;
  logic [IW-1:0]            nextIdx;

  // Drain index i maps to worker w = i % N_WORKERS, slot k = i / N_WORKERS.
  function automatic logic [COLOR_B-1:0] pickColor(input logic [IW-1:0] n);
    int w;
    int k;
    w = int'(n) % N_WORKERS;
    k = int'(n) / N_WORKERS;
    return worker_buffer[(w * JOBS_SUBDIVISION + k) * COLOR_B +: COLOR_B];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      y_q         <= '0;
      cx_q        <= '0;
      sphereY_q   <= '0;
      idx_q       <= '0;
      seen_q      <= '0;
      done_q      <= '0;
      activate_q  <= '0;
      startX_q    <= '0;
      doty_q      <= '0;
      pixYSq_q    <= '0;
      sphSq_q     <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      pxValid_q   <= 1'b0;
      pxX_q       <= '0;
      pxY_q       <= '0;
      pxColor_q   <= '0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      cx_q        <= cx_d;
      sphereY_q   <= sphereY_d;
      idx_q       <= idx_d;
      seen_q      <= seen_d;
      done_q      <= done_d;
      activate_q  <= activate_d;
      startX_q    <= startX_d;
      doty_q      <= doty_d;
      pixYSq_q    <= pixYSq_d;
      sphSq_q     <= sphSq_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
      pxValid_q   <= pxValid_d;
      pxX_q       <= pxX_d;
      pxY_q       <= pxY_d;
      pxColor_q   <= pxColor_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    cx_d        = cx_q;
    sphereY_d   = sphereY_q;
    idx_d       = idx_q;
    seen_d      = seen_q;
    done_d      = done_q;
    activate_d  = activate_q;
    startX_d    = startX_q;
    doty_d      = doty_q;
    pixYSq_d    = pixYSq_q;
    sphSq_d     = sphSq_q;
    busy_d      = busy_q;
    frameDone_d = 1'b0;
    pxValid_d   = pxValid_q;
    pxX_d       = pxX_q;
    pxY_d       = pxY_q;
    pxColor_d   = pxColor_q;
    nextIdx     = idx_q + IW'(1);

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          sphereY_d = sphere_y;
          y_d       = Y_FIRST;
          cx_d      = X_FIRST;
          busy_d    = 1'b1;
          state_d   = S_ROW_SETUP;
        end
      end

      S_ROW_SETUP: begin
        // Products are widened first so the shifted bits survive truncation.
        doty_d   = 22'((28'(y_q) * 28'(sphereY_q)) >>> FP_B);
        pixYSq_d = 16'(24'(y_q) * 24'(y_q));
        sphSq_d  = 27'($unsigned(32'(sphereY_q) * 32'(sphereY_q)) >> FP_B);
        state_d  = S_DISPATCH;
      end

      S_DISPATCH: begin
        for (int w = 0; w < N_WORKERS; w++) begin
          startX_d[w*12 +: 12] = cx_q + 12'(w);
        end
        activate_d = '1;
        seen_d     = '0;
        done_d     = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        // Done is sticky: a worker re-raising busy stays done until next dispatch.
        seen_d = seen_q | worker_busy;
        done_d = done_q | (seen_q & ~worker_busy);
        if (&done_d) begin
          activate_d = '0;
          state_d    = S_RELEASE;
        end
      end

      S_RELEASE: begin
        pxValid_d = 1'b1;
        pxX_d     = cx_q;
        pxY_d     = y_q;
        pxColor_d = pickColor('0);
        idx_d     = '0;
        state_d   = S_DRAIN;
      end

      S_DRAIN: begin
        if (px.px_ready) begin
          if (idx_q == IDX_LAST) begin
            pxValid_d = 1'b0;
            state_d   = S_NEXT;
          end else begin
            idx_d     = nextIdx;
            pxX_d     = cx_q + 12'(nextIdx);
            pxColor_d = pickColor(nextIdx);
          end
        end
      end

      S_NEXT: begin
        if (cx_q < X_LAST_CHUNK) begin
          cx_d    = cx_q + 12'(C);
          state_d = S_DISPATCH;
        end else if (y_q < Y_LAST) begin
          y_d     = y_q + 12'sd1;
          cx_d    = X_FIRST;
          state_d = S_ROW_SETUP;
        end else begin
          frameDone_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign frame_busy           = busy_q;
  assign frame_done           = frameDone_q;
  assign worker_activate      = activate_q;
  assign worker_pixel_start_x = startX_q;
  assign worker_doty          = doty_q;
  assign worker_pixel_y_sqrd  = pixYSq_q;
  assign worker_sphere_y_sqrd = sphSq_q;
  assign px.px_valid          = pxValid_q;
  assign px.px_x              = pxX_q;
  assign px.px_y              = pxY_q;
  assign px.px_color          = pxColor_q;

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Scoreboard bench for raytracing_scheduler on a 16x2 screen with four modelled workers.
// Frames push their expected pixels; a negedge monitor pops and compares each handshake.
module tb_raytracing_scheduler;
  localparam int NW = 4;
  localparam int JS = 2;
  localparam int W  = 16;
  localparam int H  = 2;
  localparam int CB = 12;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   frameStart;
  logic signed [15:0]     sphereY;
  logic                   frameBusy;
  logic                   frameDone;
  logic [NW-1:0]          workerActivate;
  logic [NW-1:0]          workerBusy = '0;
  logic [12*NW-1:0]       workerStartX;
  logic signed [21:0]     workerDoty;
  logic [15:0]            workerPixYSq;
  logic [26:0]            workerSphSq;
  logic [NW*JS*CB-1:0]    workerBuffer = '0;

  raytracing_scheduler_if #(.COLOR_B(CB)) pxIf ();

  raytracing_scheduler #(
    .N_WORKERS(NW), .JOBS_SUBDIVISION(JS), .WIDTH(W), .HEIGHT(H), .FP_B(4), .COLOR_B(CB)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_start         (frameStart),
    .sphere_y            (sphereY),
    .frame_busy          (frameBusy),
    .frame_done          (frameDone),
    .worker_activate     (workerActivate),
    .worker_busy         (workerBusy),
    .worker_pixel_start_x(workerStartX),
    .worker_doty         (workerDoty),
    .worker_pixel_y_sqrd (workerPixYSq),
    .worker_sphere_y_sqrd(workerSphSq),
    .worker_buffer       (workerBuffer),
    .px                  (pxIf.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int color;
  } pix_t;

  pix_t               expQ[$];
  int                 assertCount = 0;
  int                 failCount = 0;
  int                 doneCount = 0;
  int                 pixelsThisFrame = 0;
  int                 dispIdx = 0;
  int                 monDisp = 0;
  int                 readyMode = 0;
  int                 readyCycle = 0;
  int                 extraDelay[NW] = '{0, 0, 0, 0};
  int                 cnt[NW] = '{0, 0, 0, 0};
  logic [NW-1:0]      finished = '0;
  logic [NW-1:0]      prevActModel = '0;
  logic [NW-1:0]      prevActMon = '0;
  logic signed [15:0] curSphere = '0;
  bit                 prevValid = 0;
  bit                 stallPending = 0;
  int                 heldX, heldY, heldColor;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  // Sink readiness: always ready, or the repeating 1,0,0,1 pattern.
  always @(posedge clk) begin
    #1;
    readyCycle++;
    if (readyMode == 0) pxIf.px_ready = 1'b1;
    else pxIf.px_ready = ((readyCycle % 4) == 0) || ((readyCycle % 4) == 3);
  end

  // Worker model: busy high from 1 to 5 cycles after activate (plus any extra delay).
  always @(posedge clk) begin
    bit nb;
    #2;
    if (workerActivate != '0 && prevActModel == '0) begin
      for (int w = 0; w < NW; w++)
        for (int k = 0; k < JS; k++)
          workerBuffer[(w*JS + k)*CB +: CB] = 12'((dispIdx << 8) | (w << 4) | k);
      dispIdx++;
    end
    prevActModel = workerActivate;
    for (int w = 0; w < NW; w++) begin
      if (!workerActivate[w]) begin
        cnt[w] = 0;
        workerBusy[w] = 1'b0;
      end else begin
        if (cnt[w] == 0) finished[w] = 1'b0;
        cnt[w]++;
        nb = (cnt[w] >= 1 + extraDelay[w]) && (cnt[w] < 6 + extraDelay[w]);
        if (workerBusy[w] && !nb) finished[w] = 1'b1;
        workerBusy[w] = nb;
      end
    end
  end

  // Monitor: row constants per dispatch, activate coherence, pixel scoreboard, hold checks.
  always @(negedge clk) begin
    pix_t p;
    longint yRow;
    longint cxRow;
    if (rst) begin
      stallPending = 0;
      prevValid    = 0;
      prevActMon   = '0;
    end else begin
      if (frameDone) doneCount++;
      if (workerActivate != '0) checkOutput("activate all-or-none", longint'(workerActivate), 15);
      if (workerActivate != '0 && prevActMon == '0) begin
        yRow  = -1 + monDisp / 2;
        cxRow = -8 + 8 * (monDisp % 2);
        checkOutput("doty", longint'(workerDoty), (yRow * longint'(curSphere)) >>> 4);
        checkOutput("pixel_y_sqrd", longint'(workerPixYSq), yRow * yRow);
        checkOutput("sphere_y_sqrd", longint'(workerSphSq),
                    (longint'(curSphere) * longint'(curSphere)) >>> 4);
        for (int w = 0; w < NW; w++)
          checkOutput("start_x", longint'($signed(workerStartX[w*12 +: 12])), cxRow + w);
        monDisp++;
      end
      if (pxIf.px_valid && !prevValid)
        checkOutput("workers finished before drain", longint'(finished), 15);
      if (stallPending) begin
        checkOutput("hold valid", longint'(pxIf.px_valid), 1);
        checkOutput("hold x", longint'(pxIf.px_x), heldX);
        checkOutput("hold y", longint'(pxIf.px_y), heldY);
        checkOutput("hold color", longint'(pxIf.px_color), heldColor);
      end
      if (pxIf.px_valid && pxIf.px_ready) begin
        stallPending = 0;
        pixelsThisFrame++;
        if (expQ.size() == 0) begin
          checkOutput("expected pixel available", 0, 1);
        end else begin
          p = expQ.pop_front();
          checkOutput("pixel x", longint'(pxIf.px_x), p.x);
          checkOutput("pixel y", longint'(pxIf.px_y), p.y);
          checkOutput("pixel color", longint'(pxIf.px_color), p.color);
        end
      end else if (pxIf.px_valid) begin
        stallPending = 1;
        heldX        = int'(pxIf.px_x);
        heldY        = int'(pxIf.px_y);
        heldColor    = int'(pxIf.px_color);
      end else begin
        stallPending = 0;
      end
      prevValid  = pxIf.px_valid;
      prevActMon = workerActivate;
    end
  end

  // Starts a frame, queues its 32 expected pixels and checks the start latency.
  task automatic applyStimulus(input logic signed [15:0] sy);
    pix_t p;
    int d;
    pixelsThisFrame = 0;
    dispIdx         = 0;
    monDisp         = 0;
    curSphere       = sy;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        d = r * 2 + c;
        for (int i = 0; i < 8; i++) begin
          p.x     = -8 + 8 * c + i;
          p.y     = -1 + r;
          p.color = (d << 8) | ((i % 4) << 4) | (i / 4);
          expQ.push_back(p);
        end
      end
    sphereY    = sy;
    frameStart = 1'b1;
    @(posedge clk);
    #1;
    frameStart = 1'b0;
    sphereY    = 16'sh5555;
    checkOutput("busy at t+1", longint'(frameBusy), 1);
    checkOutput("activate at t+1", longint'(workerActivate), 0);
    @(posedge clk);
    #1;
    checkOutput("activate at t+2", longint'(workerActivate), 0);
    @(posedge clk);
    #1;
    checkOutput("activate at t+3", longint'(workerActivate), 15);
  endtask

  task automatic waitFrameDone(input int budget);
    int startDone;
    startDone = doneCount;
    for (int c = 0; c < budget && doneCount == startDone; c++) @(posedge clk);
    checkOutput("frame_done within budget", longint'(doneCount != startDone), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic endFrameChecks(input int expectedDone);
    checkOutput("pixels left in scoreboard", expQ.size(), 0);
    checkOutput("pixel count", pixelsThisFrame, 32);
    checkOutput("dispatch count", dispIdx, 4);
    checkOutput("frame_done count", doneCount, expectedDone);
    checkOutput("busy after frame", longint'(frameBusy), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int savedDone;
    rst        = 1'b1;
    frameStart = 1'b0;
    sphereY    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset frame_busy", longint'(frameBusy), 0);
    checkOutput("reset frame_done", longint'(frameDone), 0);
    checkOutput("reset activate", longint'(workerActivate), 0);
    checkOutput("reset px_valid", longint'(pxIf.px_valid), 0);
    checkOutput("reset start_x", longint'(workerStartX), 0);
    checkOutput("reset doty", longint'(workerDoty), 0);
    checkOutput("reset pixel_y_sqrd", longint'(workerPixYSq), 0);
    checkOutput("reset sphere_y_sqrd", longint'(workerSphSq), 0);
    checkOutput("reset px_x", longint'(pxIf.px_x), 0);
    checkOutput("reset px_y", longint'(pxIf.px_y), 0);
    checkOutput("reset px_color", longint'(pxIf.px_color), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] frame with sphere_y 3.0, sink always ready");
    applyStimulus(16'sh0030);
    waitFrameDone(2000);
    endFrameChecks(1);

    $display("[TB] frame with px_ready pattern 1,0,0,1");
    readyMode = 1;
    applyStimulus(-16'sh0028);
    waitFrameDone(2000);
    endFrameChecks(2);
    readyMode = 0;

    $display("[TB] frame with worker 2 delayed by 20 cycles");
    extraDelay[2] = 20;
    applyStimulus(16'sh0100);
    waitFrameDone(2000);
    endFrameChecks(3);
    extraDelay[2] = 0;

    $display("[TB] frame with a second frame_start pulsed mid-frame");
    applyStimulus(16'sh7FFF);
    repeat (10) @(posedge clk);
    #1;
    sphereY    = 16'sh1234;
    frameStart = 1'b1;
    @(posedge clk);
    #1;
    frameStart = 1'b0;
    waitFrameDone(2000);
    endFrameChecks(4);

    $display("[TB] reset during drain, then a fresh frame");
    applyStimulus(16'sh0030);
    for (int c = 0; c < 500 && !pxIf.px_valid; c++) @(negedge clk);
    checkOutput("drain reached", longint'(pxIf.px_valid), 1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("px_valid after reset", longint'(pxIf.px_valid), 0);
    checkOutput("activate after reset", longint'(workerActivate), 0);
    checkOutput("busy after reset", longint'(frameBusy), 0);
    expQ.delete();
    savedDone = doneCount;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no frame_done for aborted frame", doneCount, savedDone);
    applyStimulus(16'sh0030);
    waitFrameDone(2000);
    endFrameChecks(5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
